cap_sense_scanner: RTL and testbench

CAP_SENSE_SCANNER -- requirements
Module: cap_sense_scanner

---
 rtl/cap_sense_pkg.sv | 20 ++
 rtl/cap_pad_debounce.sv | 38 +++
 rtl/cap_sense_scanner.sv | 147 ++++++++++++++
 tb/tb_cap_sense_scanner.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cap_sense_pkg.sv
// Shared definitions for the capacitive pad scanner: scan FSM state type,
// count width and default parameter values.
package cap_sense_pkg;

   localparam int NUM_PADS             = 9;
   localparam int COUNT_W              = 16;
   localparam int DISCHARGE_CYCLES_DEF = 256;
   localparam int TIMEOUT_CYCLES_DEF   = 4000;
   localparam int THRESHOLD_DEF        = 200;
   localparam int DEBOUNCE_SCANS_DEF   = 3;

   // Scan sequence: IDLE -> DISCHARGE -> MEASURE -> EVAL -> (DISCHARGE | IDLE)
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_DISCHARGE = 2'd1,
      ST_MEASURE   = 2'd2,
      ST_EVAL      = 2'd3
   } scan_state_e;

endpackage

// File: rtl/cap_pad_debounce.sv
// Per-pad debouncer: the touched bit flips only after DEBOUNCE_SCANS
// consecutive scans whose raw reading disagrees with it.
module cap_pad_debounce
   import cap_sense_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic eval_en,
   input  logic raw,
   output logic touched
);

   localparam logic [2:0] STAB_LIMIT = 3'(DEBOUNCE_SCANS);

   logic [2:0] stab_q;

   // Count disagreeing scans; any agreeing scan restarts the count.
   always_ff @(posedge clock) begin
      if (!reset) begin
         stab_q  <= '0;
         touched <= 1'b0;
      end else if (eval_en) begin
         if (raw != touched) begin
            if (stab_q + 3'd1 == STAB_LIMIT) begin
               touched <= ~touched;
               stab_q  <= '0;
            end else begin
               stab_q <= stab_q + 3'd1;
            end
         end else begin
            stab_q <= '0;
         end
      end
   end

endmodule

// File: rtl/cap_sense_scanner.sv
// Capacitive pad scanner: discharges all pads through a shared drive pin,
// then times how long each pad takes to charge past its comparator. Slow
// pads (large count) are raw-touched; results are debounced per pad.
//
// Handshake: there is no valid/ready pair. touch_valid is a one-cycle
// strobe in the cycle the debounced touched vector is updated; it has no
// back-pressure and fires exactly once per completed scan.
module cap_sense_scanner #(
   parameter int NUM_PADS         = cap_sense_pkg::NUM_PADS,
   parameter int DISCHARGE_CYCLES = cap_sense_pkg::DISCHARGE_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES   = cap_sense_pkg::TIMEOUT_CYCLES_DEF,
   parameter int THRESHOLD        = cap_sense_pkg::THRESHOLD_DEF,
   parameter int DEBOUNCE_SCANS   = cap_sense_pkg::DEBOUNCE_SCANS_DEF
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              enable,
   input  logic [NUM_PADS-1:0]               capacitive_sensors_in,
   output logic                              capacitive_sensors_out,
   output logic [NUM_PADS-1:0]               touched,
   output logic                              touch_valid,
   input  logic [3:0]                        count_sel,
   output logic [cap_sense_pkg::COUNT_W-1:0] count_data,
   output logic                              busy,
   output logic [1:0]                        state_dbg
);

   import cap_sense_pkg::*;

   localparam logic [COUNT_W-1:0] DISCHARGE_LAST = COUNT_W'(DISCHARGE_CYCLES - 1);
   localparam logic [COUNT_W-1:0] TIMEOUT_LAST   = COUNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [COUNT_W-1:0] TIMEOUT_SAT    =
      (TIMEOUT_CYCLES > 65535) ? {COUNT_W{1'b1}} : COUNT_W'(TIMEOUT_CYCLES);
   localparam logic [COUNT_W-1:0] THRESH_W       = COUNT_W'(THRESHOLD);

   scan_state_e          state, state_nx;
   logic [NUM_PADS-1:0]  sync1_q, sync_in;
   logic [NUM_PADS-1:0]  latched_q;
   logic [NUM_PADS-1:0]  raw;
   logic [COUNT_W-1:0]   cycle_cnt;
   logic [COUNT_W-1:0]   meas_q  [NUM_PADS];
   logic [COUNT_W-1:0]   count_q [NUM_PADS];
   logic                 meas_done;

   assign meas_done = (&(latched_q | sync_in)) || (cycle_cnt == TIMEOUT_LAST);
   assign busy      = (state != ST_IDLE);
   assign state_dbg = state;

   // Two-flop synchroniser for the asynchronous comparator inputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync1_q <= '0;
         sync_in <= '0;
      end else begin
         sync1_q <= capacitive_sensors_in;
         sync_in <= sync1_q;
      end
   end

   // Scan FSM state register.
   always_ff @(posedge clock) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic and drive pin; the pin is high only while measuring.
   always_comb begin
      state_nx               = state;
      capacitive_sensors_out = 1'b0;
      case (state)
         ST_IDLE:      if (enable) state_nx = ST_DISCHARGE;
         ST_DISCHARGE: if (cycle_cnt == DISCHARGE_LAST) state_nx = ST_MEASURE;
         ST_MEASURE: begin
            capacitive_sensors_out = 1'b1;
            if (meas_done) state_nx = ST_EVAL;
         end
         ST_EVAL:      state_nx = enable ? ST_DISCHARGE : ST_IDLE;
         default:      state_nx = ST_IDLE;
      endcase
   end

   // Cycle counter, per-pad rise latching and end-of-measure count publish.
   always_ff @(posedge clock) begin
      if (!reset) begin
         cycle_cnt <= '0;
         latched_q <= '0;
         for (int i = 0; i < NUM_PADS; i++) begin
            meas_q[i]  <= '0;
            count_q[i] <= '0;
         end
      end else begin
         case (state)
            ST_DISCHARGE: begin
               latched_q <= '0;
               cycle_cnt <= (cycle_cnt == DISCHARGE_LAST) ? '0 : cycle_cnt + 1'b1;
            end
            ST_MEASURE: begin
               if (cycle_cnt != {COUNT_W{1'b1}}) cycle_cnt <= cycle_cnt + 1'b1;
               for (int i = 0; i < NUM_PADS; i++) begin
                  if (!latched_q[i] && sync_in[i]) begin
                     latched_q[i] <= 1'b1;
                     meas_q[i]    <= cycle_cnt;
                  end
                  // Publishing only here keeps count_data stable mid-scan.
                  if (meas_done) begin
                     if (latched_q[i])   count_q[i] <= meas_q[i];
                     else if (sync_in[i]) count_q[i] <= cycle_cnt;
                     else                 count_q[i] <= TIMEOUT_SAT;
                  end
               end
            end
            default: cycle_cnt <= '0;
         endcase
      end
   end

   // Raw touch decision: a slow-charging pad carries extra finger capacitance.
   always_comb begin
      raw = '0;
      for (int i = 0; i < NUM_PADS; i++) raw[i] = (count_q[i] >= THRESH_W);
   end

   // Strobe marking the cycle the debounced vector reflects the new scan.
   always_ff @(posedge clock) begin
      if (!reset) touch_valid <= 1'b0;
      else        touch_valid <= (state == ST_EVAL);
   end

   // Combinational read-back of the last completed raw count.
   always_comb begin
      count_data = '0;
      if (int'(count_sel) < NUM_PADS) count_data = count_q[count_sel];
   end

   for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
      cap_pad_debounce #(
         .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_debounce (
         .clock  (clock),
         .reset  (reset),
         .eval_en(state == ST_EVAL),
         .raw    (raw[g]),
         .touched(touched[g])
      );
   end

endmodule

// File: tb/tb_cap_sense_scanner.sv
// Directed bench for cap_sense_scanner with a small RC pad model: pad i
// rises n_pad[i] cycles after the drive pin rises and falls with it.
module tb_cap_sense_scanner;

   localparam int NP    = 9;
   localparam int NEVER = 100000;

   logic        clock  = 1'b0;
   logic        reset  = 1'b0;
   logic        enable = 1'b0;
   logic [8:0]  pads_in = '0;
   logic        drive_out;
   logic [8:0]  touched;
   logic        touch_valid;
   logic [3:0]  count_sel = '0;
   logic [15:0] count_data;
   logic        busy;
   logic [1:0]  state_dbg;

   int n_pad [NP];
   int age      = 0;
   int tv_total = 0;
   int checks   = 0;
   int passed   = 0;

   cap_sense_scanner #(
      .NUM_PADS        (9),
      .DISCHARGE_CYCLES(4),
      .TIMEOUT_CYCLES  (64),
      .THRESHOLD       (20),
      .DEBOUNCE_SCANS  (2)
   ) dut (
      .clock                 (clock),
      .reset                 (reset),
      .enable                (enable),
      .capacitive_sensors_in (pads_in),
      .capacitive_sensors_out(drive_out),
      .touched               (touched),
      .touch_valid           (touch_valid),
      .count_sel             (count_sel),
      .count_data            (count_data),
      .busy                  (busy),
      .state_dbg             (state_dbg)
   );

   // Clock.
   always #5 clock = ~clock;

   // Pad model: counts negedges with drive high; pad rises N cycles later.
   always @(negedge clock) begin
      if (drive_out === 1'b1) age = age + 1;
      else                    age = 0;
      for (int i = 0; i < NP; i++)
         pads_in[i] = (drive_out === 1'b1) && (age > n_pad[i]);
   end

   // Count touch_valid pulses.
   always @(posedge clock) begin
      if (touch_valid === 1'b1) tv_total = tv_total + 1;
   end

   task automatic set_all_n(input int n);
      for (int i = 0; i < NP; i++) n_pad[i] = n;
   endtask

   task automatic do_reset();
      enable = 1'b0;
      reset  = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset  = 1'b1;
      enable = 1'b1;
   endtask

   // Wait for the touch_valid strobe, counting MEASURE cycles on the way.
   task automatic wait_scan(output int mlen);
      bit ok;
      mlen = 0;
      ok   = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clock);
         if (drive_out === 1'b1) mlen++;
         if (touch_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) $display("FAIL scan_timeout: touch_valid got none want pulse within 400 cycles");
      else passed++;
   endtask

   task automatic wait_drive_high();
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clock);
         if (drive_out === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) $display("FAIL drive_timeout: drive_out got low want high within 200 cycles");
      else passed++;
   endtask

   task automatic test_reset();
      set_all_n(5);
      enable = 1'b1;
      reset  = 1'b0;
      repeat (5) @(posedge clock);
      @(negedge clock);
      checks++;
      if (drive_out !== 1'b0) $display("FAIL reset_drive: got %b want 0", drive_out); else passed++;
      checks++;
      if (touched !== 9'h000) $display("FAIL reset_touched: got %h want 000", touched); else passed++;
      checks++;
      if (touch_valid !== 1'b0) $display("FAIL reset_tv: got %b want 0", touch_valid); else passed++;
      checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      checks++;
      if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d want 0", state_dbg); else passed++;
      for (int s = 0; s < 16; s++) begin
         count_sel = 4'(s);
         #1;
         checks++;
         if (count_data !== 16'd0) $display("FAIL reset_count[%0d]: got %0d want 0", s, count_data);
         else passed++;
      end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_all_short();
      int mlen;
      int tv0;
      tv0 = tv_total;
      for (int scan = 0; scan < 2; scan++) begin
         wait_scan(mlen);
         checks++;
         if (mlen != 8) $display("FAIL short_mlen%0d: got %0d want 8", scan, mlen); else passed++;
         checks++;
         if (touched !== 9'h000) $display("FAIL short_touched%0d: got %h want 000", scan, touched); else passed++;
         for (int s = 0; s < NP; s++) begin
            count_sel = 4'(s);
            #1;
            checks++;
            if (count_data !== 16'd7) $display("FAIL short_count[%0d]: got %0d want 7", s, count_data);
            else passed++;
         end
      end
      @(negedge clock);
      checks++;
      if (touch_valid !== 1'b0) $display("FAIL short_tv_width: got %b want 0", touch_valid); else passed++;
      checks++;
      if (tv_total - tv0 != 2) $display("FAIL short_tv_count: got %0d want 2", tv_total - tv0); else passed++;
   endtask

   task automatic test_long_pad();
      int mlen;
      set_all_n(5);
      n_pad[4] = 30;
      do_reset();
      wait_scan(mlen);
      checks++;
      if (mlen != 33) $display("FAIL long_mlen: got %0d want 33", mlen); else passed++;
      checks++;
      if (touched !== 9'h000) $display("FAIL long_touched1: got %h want 000", touched); else passed++;
      count_sel = 4'd4;
      #1;
      checks++;
      if (count_data !== 16'd32) $display("FAIL long_count4: got %0d want 32", count_data); else passed++;
      count_sel = 4'd0;
      #1;
      checks++;
      if (count_data !== 16'd7) $display("FAIL long_count0: got %0d want 7", count_data); else passed++;
      wait_scan(mlen);
      checks++;
      if (touched !== 9'h010) $display("FAIL long_touched2: got %h want 010", touched); else passed++;
   endtask

   task automatic test_timeout_bounce();
      int mlen;
      set_all_n(5);
      n_pad[0] = 30;
      n_pad[8] = NEVER;
      do_reset();
      wait_scan(mlen);
      checks++;
      if (mlen != 64) $display("FAIL tmo_mlen: got %0d want 64", mlen); else passed++;
      count_sel = 4'd8;
      #1;
      checks++;
      if (count_data !== 16'd64) $display("FAIL tmo_count8: got %0d want 64", count_data); else passed++;
      count_sel = 4'd0;
      #1;
      checks++;
      if (count_data !== 16'd32) $display("FAIL tmo_count0_long: got %0d want 32", count_data); else passed++;
      checks++;
      if (touched !== 9'h000) $display("FAIL tmo_touched1: got %h want 000", touched); else passed++;
      n_pad[0] = 5;
      wait_scan(mlen);
      checks++;
      if (touched !== 9'h100) $display("FAIL tmo_touched2: got %h want 100", touched); else passed++;
      count_sel = 4'd0;
      #1;
      checks++;
      if (count_data !== 16'd7) $display("FAIL tmo_count0_short: got %0d want 7", count_data); else passed++;
      n_pad[0] = 30;
      wait_scan(mlen);
      checks++;
      if (touched !== 9'h100) $display("FAIL bounce_touched3: got %h want 100", touched); else passed++;
      checks++;
      if (mlen != 64) $display("FAIL tmo_mlen3: got %0d want 64", mlen); else passed++;
   endtask

   task automatic test_reset_mid_measure();
      int tv0;
      wait_drive_high();
      repeat (3) @(negedge clock);
      tv0   = tv_total;
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (drive_out !== 1'b0) $display("FAIL midrst_drive: got %b want 0", drive_out); else passed++;
      checks++;
      if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
      checks++;
      if (touched !== 9'h000) $display("FAIL midrst_touched: got %h want 000", touched); else passed++;
      checks++;
      if (touch_valid !== 1'b0) $display("FAIL midrst_tv: got %b want 0", touch_valid); else passed++;
      repeat (5) @(negedge clock);
      checks++;
      if (tv_total != tv0) $display("FAIL midrst_no_tv: got %0d pulses want 0", tv_total - tv0); else passed++;
      enable = 1'b0;
      reset  = 1'b1;
   endtask

   task automatic test_enable_drop();
      int mlen;
      int tv0;
      set_all_n(5);
      enable = 1'b1;
      wait_drive_high();
      repeat (2) @(negedge clock);
      tv0    = tv_total;
      enable = 1'b0;
      wait_scan(mlen);
      @(negedge clock);
      checks++;
      if (touch_valid !== 1'b0) $display("FAIL endrop_tv_width: got %b want 0", touch_valid); else passed++;
      checks++;
      if (busy !== 1'b0) $display("FAIL endrop_busy: got %b want 0", busy); else passed++;
      checks++;
      if (state_dbg !== 2'd0) $display("FAIL endrop_state: got %0d want 0", state_dbg); else passed++;
      repeat (10) @(negedge clock);
      checks++;
      if (drive_out !== 1'b0) $display("FAIL endrop_drive: got %b want 0", drive_out); else passed++;
      checks++;
      if (tv_total - tv0 != 1) $display("FAIL endrop_tv_count: got %0d want 1", tv_total - tv0); else passed++;
      count_sel = 4'd3;
      #1;
      checks++;
      if (count_data !== 16'd7) $display("FAIL endrop_count3: got %0d want 7", count_data); else passed++;
   endtask

   initial begin
      set_all_n(5);
      test_reset();
      test_all_short();
      test_long_pad();
      test_timeout_bounce();
      test_reset_mid_measure();
      test_enable_drop();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
